// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU control decoder with single/multi-cycle sequencing
module alu_ctrl_seq #(
    parameter int WIDTH = 16,
    parameter int OPW   = 5,
    parameter int FW    = 2,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  OpCode,
    input  logic [FW-1:0]   oper,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            invA,
    output logic            invB,
    output logic            Cin,
    output logic            multi,
    output logic [CNTW-1:0] step,
    output logic            last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        ITER   = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] STEP_LAST = CNTW'(WIDTH - 1);

    state_t     state;
    logic [2:0] dec_inv;
    logic       dec_mul;

    // Decode {OpCode,oper} into {invA,invB,Cin}; the entries are disjoint
    always_comb begin
        dec_inv = 3'b000;
        dec_mul = 1'b0;
        casez ({OpCode, oper})
            7'b01001??: dec_inv = 3'b101;   // SUBI
            7'b10110??: dec_inv = 3'b011;   // RORI
            7'b1101010: dec_inv = 3'b011;   // ROR
            7'b1101101: dec_inv = 3'b101;   // SUB
            7'b11101??: dec_inv = 3'b011;   // SLT
            7'b11110??: dec_inv = 3'b011;   // SLE
            7'b11100??: dec_mul = 1'b1;     // MUL, iterates WIDTH times
            default:    dec_inv = 3'b000;
        endcase
    end

    // Sequencer: accept in IDLE, hold the word until consumed, step through MUL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            invA      <= 1'b0;
            invB      <= 1'b0;
            Cin       <= 1'b0;
            multi     <= 1'b0;
            step      <= '0;
            last      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        {invA, invB, Cin} <= dec_inv;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        step      <= '0;
                        if (dec_mul) begin
                            state <= ITER;
                            multi <= 1'b1;
                            last  <= (WIDTH == 1);
                        end else begin
                            state <= SINGLE;
                            multi <= 1'b0;
                            last  <= 1'b1;
                        end
                    end
                end
                SINGLE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        invA      <= 1'b0;
                        invB      <= 1'b0;
                        Cin       <= 1'b0;
                        multi     <= 1'b0;
                        step      <= '0;
                        last      <= 1'b0;
                    end
                end
                ITER: begin
                    if (out_ready) begin
                        if (last) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            invA      <= 1'b0;
                            invB      <= 1'b0;
                            Cin       <= 1'b0;
                            multi     <= 1'b0;
                            step      <= '0;
                            last      <= 1'b0;
                        end else begin
                            step <= step + 1'b1;
                            last <= ((step + 1'b1) == STEP_LAST);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
